// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with configurable width, per-half writes with same-cycle read
// bypass, and a two-cycle multiply-accumulate path (MADD/MSUB style) with flush.
module hilo_acc_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [1:0]            op_i,
  input  logic [1:0]            we_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic [2*DATA_W-1:0]   prod_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  busy_o
);

  localparam int unsigned AccW = 2 * DATA_W;

  typedef enum logic [1:0] {
    OpWrite  = 2'd0,
    OpAccAdd = 2'd1,
    OpAccSub = 2'd2,
    OpClear  = 2'd3
  } op_e;

  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] stage_q, stage_d;
  logic            pend_q, pend_d;
  logic            accept;
  op_e             op;

  assign op = op_e'(op_i);

  // Handshake: no acceptance in reset, while an accumulate is pending, or under flush.
  always_comb begin
    op_ready_o = !rst && !pend_q;
    busy_o     = !rst && pend_q;
    accept     = op_valid_i && op_ready_o && !flush_i;
  end

  // Next-state: finish a pending accumulate, otherwise apply an accepted operation.
  always_comb begin
    acc_d   = acc_q;
    stage_d = stage_q;
    pend_d  = pend_q;
    if (pend_q) begin
      // Second cycle of the accumulate; a flush drops the staged addend.
      pend_d = 1'b0;
      if (!flush_i) begin
        acc_d = acc_q + stage_q;
      end
    end else if (accept) begin
      unique case (op)
        OpWrite: begin
          if (we_i[1]) acc_d[AccW-1:DATA_W] = hi_i;
          if (we_i[0]) acc_d[DATA_W-1:0]    = lo_i;
        end
        OpAccAdd: begin
          stage_d = prod_i;
          pend_d  = 1'b1;
        end
        OpAccSub: begin
          // Two's-complement negation so the second cycle is always an add.
          stage_d = ~prod_i + AccW'(1);
          pend_d  = 1'b1;
        end
        OpClear: begin
          acc_d = '0;
        end
        default: ;
      endcase
    end
  end

  // Read path: stored value, with per-half bypass of an accepted WRITE or CLEAR.
  always_comb begin
    hi_o = acc_q[AccW-1:DATA_W];
    lo_o = acc_q[DATA_W-1:0];
    if (rst) begin
      hi_o = '0;
      lo_o = '0;
    end else if (accept && (op == OpWrite)) begin
      if (we_i[1]) hi_o = hi_i;
      if (we_i[0]) lo_o = lo_i;
    end else if (accept && (op == OpClear)) begin
      hi_o = '0;
      lo_o = '0;
    end
  end

  // State registers with synchronous reset; reset discards any pending accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      stage_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      stage_q <= stage_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Scoreboard bench for hilo_acc_unit: a 32-bit and a 16-bit instance see the same
// stimulus (truncated for the narrow one); expected outputs per cycle are queued by
// the driver from a reference model and popped/compared by a negedge monitor.
module tb_hilo_acc_unit;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op;
  logic [1:0]  we;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic [63:0] prod;
  logic        flush;

  logic [31:0] hi32, lo32;
  logic        rdy32, busy32;
  logic [15:0] hi16, lo16;
  logic        rdy16, busy16;

  hilo_acc_unit #(.DATA_W(32)) u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .op_valid_i (op_valid),
    .op_ready_o (rdy32),
    .op_i       (op),
    .we_i       (we),
    .hi_i       (hi_in),
    .lo_i       (lo_in),
    .prod_i     (prod),
    .flush_i    (flush),
    .hi_o       (hi32),
    .lo_o       (lo32),
    .busy_o     (busy32)
  );

  hilo_acc_unit #(.DATA_W(16)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .op_valid_i (op_valid),
    .op_ready_o (rdy16),
    .op_i       (op),
    .we_i       (we),
    .hi_i       (hi_in[15:0]),
    .lo_i       (lo_in[15:0]),
    .prod_i     (prod[31:0]),
    .flush_i    (flush),
    .hi_o       (hi16),
    .lo_o       (lo16),
    .busy_o     (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi32;
    logic [31:0] lo32;
    logic [15:0] hi16;
    logic [15:0] lo16;
    logic        rdy;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: architectural accumulator values and a pending addend.
  logic [63:0] m_acc32 = '0;
  logic [63:0] m_inc32 = '0;
  logic [31:0] m_acc16 = '0;
  logic [31:0] m_inc16 = '0;
  logic        m_pend  = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, req, $time);
  endfunction

  // Monitor: one expected record per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".hi32"},   64'(hi32),   64'(e.hi32));
      chk({e.tag, ".lo32"},   64'(lo32),   64'(e.lo32));
      chk({e.tag, ".hi16"},   64'(hi16),   64'(e.hi16));
      chk({e.tag, ".lo16"},   64'(lo16),   64'(e.lo16));
      chk({e.tag, ".rdy32"},  64'(rdy32),  64'(e.rdy));
      chk({e.tag, ".busy32"}, 64'(busy32), 64'(e.busy));
      chk({e.tag, ".rdy16"},  64'(rdy16),  64'(e.rdy));
      chk({e.tag, ".busy16"}, 64'(busy16), 64'(e.busy));
    end
  end

  // Drive one cycle, queue its expected outputs, then advance the model past the edge.
  task automatic step(string tag, logic r, logic v, logic [1:0] o, logic [1:0] w,
                      logic [31:0] h, logic [31:0] l, logic [63:0] p, logic f);
    exp_t e;
    logic ok;
    @(posedge clk);
    #1;
    rst = r; op_valid = v; op = o; we = w; hi_in = h; lo_in = l; prod = p; flush = f;
    e.tag  = tag;
    ok     = !r && v && !m_pend && !f;
    e.hi32 = m_acc32[63:32];
    e.lo32 = m_acc32[31:0];
    e.hi16 = m_acc16[31:16];
    e.lo16 = m_acc16[15:0];
    e.rdy  = !r && !m_pend;
    e.busy = !r && m_pend;
    if (r) begin
      e.hi32 = '0; e.lo32 = '0; e.hi16 = '0; e.lo16 = '0;
    end else if (ok && o == OP_WR) begin
      if (w[1]) begin e.hi32 = h; e.hi16 = h[15:0]; end
      if (w[0]) begin e.lo32 = l; e.lo16 = l[15:0]; end
    end else if (ok && o == OP_CLR) begin
      e.hi32 = '0; e.lo32 = '0; e.hi16 = '0; e.lo16 = '0;
    end
    sb.push_back(e);

    if (r) begin
      m_acc32 = '0; m_acc16 = '0; m_pend = 1'b0;
    end else if (m_pend) begin
      if (!f) begin
        m_acc32 = m_acc32 + m_inc32;
        m_acc16 = m_acc16 + m_inc16;
      end
      m_pend = 1'b0;
    end else if (ok) begin
      case (o)
        OP_WR: begin
          if (w[1]) begin m_acc32[63:32] = h; m_acc16[31:16] = h[15:0]; end
          if (w[0]) begin m_acc32[31:0]  = l; m_acc16[15:0]  = l[15:0]; end
        end
        OP_ADD: begin m_inc32 = p; m_inc16 = p[31:0]; m_pend = 1'b1; end
        OP_SUB: begin
          m_inc32 = 64'd0 - p;
          m_inc16 = 32'd0 - p[31:0];
          m_pend  = 1'b1;
        end
        default: begin m_acc32 = '0; m_acc16 = '0; end
      endcase
    end
  endtask

  task automatic idle(string tag);
    step(tag, 1'b0, 1'b0, OP_WR, 2'b00, 32'h0, 32'h0, 64'h0, 1'b0);
  endtask

  task automatic wr(string tag, logic [1:0] w, logic [31:0] h, logic [31:0] l);
    step(tag, 1'b0, 1'b1, OP_WR, w, h, l, 64'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = OP_WR; we = 2'b00;
    hi_in = '0; lo_in = '0; prod = '0; flush = 1'b0;

    // Reset then idle.
    step("rst0", 1'b1, 1'b0, OP_WR, 2'b00, 32'h0, 32'h0, 64'h0, 1'b0);
    step("rst1", 1'b1, 1'b1, OP_WR, 2'b11, 32'h1, 32'h2, 64'h0, 1'b0);
    idle("idle");

    // Partial writes with bypass.
    wr("wr_hi", 2'b10, 32'hDEADBEEF, 32'h11111111);
    wr("wr_lo", 2'b01, 32'h22222222, 32'h12345678);
    idle("wr_both");
    wr("wr_nop", 2'b00, 32'h33333333, 32'h44444444);

    // Accumulate wrap.
    wr("wrap_set", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step("wrap_add", 1'b0, 1'b1, OP_ADD, 2'b00, 32'h0, 32'h0, 64'h2, 1'b0);
    idle("wrap_pend");
    idle("wrap_res");

    // Subtract through zero.
    wr("sub_set", 2'b11, 32'h0, 32'h5);
    step("sub_req", 1'b0, 1'b1, OP_SUB, 2'b00, 32'h0, 32'h0, 64'h7, 1'b0);
    idle("sub_pend");
    idle("sub_res");

    // Flush of a pending accumulate, and a flushed request.
    wr("fl_set", 2'b11, 32'h0, 32'h10);
    step("fl_add", 1'b0, 1'b1, OP_ADD, 2'b00, 32'h0, 32'h0, 64'h20, 1'b0);
    step("fl_pend", 1'b0, 1'b0, OP_WR, 2'b00, 32'h0, 32'h0, 64'h0, 1'b1);
    idle("fl_res");
    step("fl_req", 1'b0, 1'b1, OP_WR, 2'b11, 32'hAAAAAAAA, 32'hBBBBBBBB, 64'h0, 1'b1);
    idle("fl_req_res");
    step("fl_clr", 1'b0, 1'b1, OP_CLR, 2'b00, 32'h0, 32'h0, 64'h0, 1'b1);

    // WRITE held while not ready commits in the first ready cycle.
    step("hold_add", 1'b0, 1'b1, OP_ADD, 2'b00, 32'h0, 32'h0, 64'h1, 1'b0);
    wr("hold_wait", 2'b11, 32'h55, 32'h66);
    wr("hold_go", 2'b11, 32'h55, 32'h66);
    idle("hold_res");

    // CLEAR bypass.
    step("clr", 1'b0, 1'b1, OP_CLR, 2'b00, 32'h0, 32'h0, 64'h0, 1'b0);
    idle("clr_res");

    // Reset during a pending accumulate.
    wr("rm_set", 2'b11, 32'h7, 32'h9);
    step("rm_add", 1'b0, 1'b1, OP_ADD, 2'b00, 32'h0, 32'h0, 64'h3, 1'b0);
    step("rm_rst", 1'b1, 1'b0, OP_WR, 2'b00, 32'h0, 32'h0, 64'h0, 1'b0);
    idle("rm_res");
    idle("rm_res2");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] p;
      p = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15))
                                      : {$urandom, $urandom};
      step("rnd", ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           $urandom, $urandom, p, ($urandom_range(0, 7) == 0));
    end
    idle("tail");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
